// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: start/result handshake plus the function-block input/output bus
interface truth_table_sweeper_if #(parameter int NUM_IMPL = 4);
  logic                start;
  logic                pause;
  logic [3:0]          vector;
  logic [NUM_IMPL-1:0] impl_out;
  logic                busy;
  logic                done;
  logic                pass;
  logic [4:0]          err_count;
  logic [NUM_IMPL-1:0] fail_mask;
  logic [3:0]          first_fail_vec;
  logic [NUM_IMPL-1:0] first_fail_mask;
  modport master (
    output start, pause, impl_out,
    input  vector, busy, done, pass, err_count, fail_mask, first_fail_vec, first_fail_mask
  );
  modport slave (
    input  start, pause, impl_out,
    output vector, busy, done, pass, err_count, fail_mask, first_fail_vec, first_fail_mask
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps all 16 input vectors and checks parallel implementations against a golden table
module truth_table_sweeper #(
  parameter int          NUM_IMPL = 4,
  parameter logic [15:0] TRUTH    = 16'h24D5
) (
  input logic clock,
  input logic reset,
  truth_table_sweeper_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  state_t              state_q, state_d;
  logic [3:0]          vec_q, vec_d;
  logic [4:0]          err_q, err_d;
  logic [NUM_IMPL-1:0] fm_q, fm_d;
  logic [3:0]          ffv_q, ffv_d;
  logic [NUM_IMPL-1:0] ffm_q, ffm_d;
  logic                pass_q, pass_d;
  logic [NUM_IMPL-1:0] mism;
  assign mism = bus.impl_out ^ {NUM_IMPL{TRUTH[vec_q]}};
  // next state: clear results on start, accumulate mismatches per unpaused sweep cycle, latch pass on the last vector
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    fm_d    = fm_q;
    ffv_d   = ffv_q;
    ffm_d   = ffm_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = SWEEP;
        vec_d   = '0;
        err_d   = '0;
        fm_d    = '0;
        ffv_d   = '0;
        ffm_d   = '0;
        pass_d  = 1'b0;
      end
      SWEEP: if (!bus.pause) begin
        if (mism != '0) begin
          err_d = err_q + 5'(err_q != 5'd16);
          fm_d  = fm_q | mism;
          ffv_d = (fm_q == '0) ? vec_q : ffv_q;
          ffm_d = (fm_q == '0) ? mism  : ffm_q;
        end
        vec_d = vec_q + 4'd1;
        if (vec_q == 4'd15) begin
          state_d = DONE;
          pass_d  = (err_d == 5'd0);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and result registers, cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      fm_q    <= '0;
      ffv_q   <= '0;
      ffm_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fm_q    <= fm_d;
      ffv_q   <= ffv_d;
      ffm_q   <= ffm_d;
      pass_q  <= pass_d;
    end
  end
  assign bus.vector          = vec_q;
  assign bus.busy            = (state_q == SWEEP);
  assign bus.done            = (state_q == DONE);
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_q;
  assign bus.fail_mask       = fm_q;
  assign bus.first_fail_vec  = ffv_q;
  assign bus.first_fail_mask = ffm_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: table-driven sweeps with a result scoreboard plus pause, restart, reset and held-start sequences
module tb_truth_table_sweeper;
  localparam int          N     = 4;
  localparam logic [15:0] TRUTH = 16'h24D5;
  typedef struct {
    string       name;
    logic [63:0] flip;
    logic [4:0]  err;
    logic [3:0]  fm;
    logic [3:0]  ffv;
    logic [3:0]  ffm;
    logic        pass;
  } tv_t;
  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] cur_flip = '0;
  int          checks = 0;
  int          fails = 0;
  tv_t         q[$];
  tv_t         tab[5];
  truth_table_sweeper_if #(.NUM_IMPL(N)) bus();
  truth_table_sweeper #(.NUM_IMPL(N), .TRUTH(TRUTH)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clock = ~clock;
  assign bus.impl_out = {N{TRUTH[bus.vector]}} ^ cur_flip[bus.vector*4 +: 4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_sweep(input tv_t tv, input bit do_pause, input bit repulse, input int exp_lat);
    int  n = 1;
    int  pc = 0;
    bit  seen = 0;
    tv_t e;
    cur_flip = tv.flip;
    q.push_back(tv);
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    chk({tv.name, "_busy_start"}, 32'(bus.busy), 1);
    chk({tv.name, "_vec0"}, 32'(bus.vector), 0);
    while (!seen && n < 40) begin
      if (bus.done) seen = 1;
      else begin
        bus.start = repulse && (bus.vector == 4'd4);
        if (do_pause && pc > 0 && pc < 3) chk({tv.name, "_pause_hold"}, 32'(bus.vector), 7);
        bus.pause = do_pause && (bus.vector == 4'd7) && pc < 3;
        if (bus.pause) pc++;
        @(negedge clock);
        n++;
      end
    end
    bus.start = 1'b0;
    bus.pause = 1'b0;
    if (!seen) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: no done after %0d cycles, expected at %0d", tv.name, n, exp_lat);
      void'(q.pop_front());
    end else begin
      e = q.pop_front();
      chk({e.name, "_latency"}, 32'(n), 32'(exp_lat));
      chk({e.name, "_busy_done"}, 32'(bus.busy), 0);
      chk({e.name, "_err_count"}, 32'(bus.err_count), 32'(e.err));
      chk({e.name, "_fail_mask"}, 32'(bus.fail_mask), 32'(e.fm));
      chk({e.name, "_first_vec"}, 32'(bus.first_fail_vec), 32'(e.ffv));
      chk({e.name, "_first_mask"}, 32'(bus.first_fail_mask), 32'(e.ffm));
      chk({e.name, "_pass"}, 32'(bus.pass), 32'(e.pass));
      @(negedge clock);
      chk({e.name, "_done_pulse"}, 32'(bus.done), 0);
      chk({e.name, "_err_stable"}, 32'(bus.err_count), 32'(e.err));
      chk({e.name, "_pass_stable"}, 32'(bus.pass), 32'(e.pass));
    end
  endtask

  initial begin
    int  n;
    bit  d_seen;
    tab[0] = '{"clean",      64'h0000_0000_0000_0000, 5'd0,  4'b0000, 4'd0,  4'b0000, 1'b1};
    tab[1] = '{"i0_v10",     64'h0000_0100_0000_0000, 5'd1,  4'b0001, 4'd10, 4'b0001, 1'b0};
    tab[2] = '{"i2inv_i3v5", 64'h4444_4444_44C4_4444, 5'd16, 4'b1100, 4'd0,  4'b0100, 1'b0};
    tab[3] = '{"i1_v3_v15",  64'h2000_0000_0000_2000, 5'd2,  4'b0010, 4'd3,  4'b0010, 1'b0};
    tab[4] = '{"i3_v15",     64'h8000_0000_0000_0000, 5'd1,  4'b1000, 4'd15, 4'b1000, 1'b0};
    reset = 1'b1;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_vector", 32'(bus.vector), 0);
    chk("rst_err", 32'(bus.err_count), 0);
    chk("rst_pass", 32'(bus.pass), 0);
    reset = 1'b0;
    bus.pause = 1'b1;
    @(negedge clock);
    bus.pause = 1'b0;
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_pass", 32'(bus.pass), 0);
    for (int i = 0; i < 5; i++) run_sweep(tab[i], 1'b0, 1'b0, 17);
    run_sweep(tab[1], 1'b1, 1'b0, 20);
    run_sweep(tab[0], 1'b0, 1'b1, 17);
    // reset mid-sweep at vector 9: immediate clear, no done
    cur_flip = '0;
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    n = 0;
    while (bus.vector != 4'd9 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("rst_mid_reached_v9", 32'(bus.vector), 9);
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(bus.busy), 0);
    chk("rst_mid_vector", 32'(bus.vector), 0);
    chk("rst_mid_err", 32'(bus.err_count), 0);
    chk("rst_mid_pass", 32'(bus.pass), 0);
    @(negedge clock);
    reset = 1'b0;
    d_seen = 0;
    repeat (20) begin
      @(negedge clock);
      if (bus.done) d_seen = 1;
    end
    chk("rst_mid_no_done", 32'(d_seen), 0);
    // start held high: back-to-back sweeps, one idle cycle, results cleared
    cur_flip = tab[1].flip;
    @(negedge clock);
    bus.start = 1'b1;
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("held_first_done", 32'(bus.done), 1);
    chk("held_first_err", 32'(bus.err_count), 1);
    @(negedge clock);
    chk("held_idle_busy", 32'(bus.busy), 0);
    chk("held_idle_done", 32'(bus.done), 0);
    @(negedge clock);
    chk("held_restart_busy", 32'(bus.busy), 1);
    chk("held_cleared_err", 32'(bus.err_count), 0);
    chk("held_cleared_mask", 32'(bus.fail_mask), 0);
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("held_second_done", 32'(bus.done), 1);
    chk("held_second_vec", 32'(bus.first_fail_vec), 10);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
